mc_path_gen: RTL and testbench

//  Monte Carlo path source for the option-pricing datapath. Each path starts at

---
 rtl/mc_path_gen_if.sv | 11 +
 rtl/mc_path_gen.sv | 168 ++++++++++++++++
 tb/tb_mc_path_gen.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_path_gen_if.sv
// Terminal-price stream from the path generator to the pricing stage (valid/ready, held until accepted).
interface mc_path_gen_if #(
   parameter int W = 12
) ();
   logic [W-1:0] path;
   logic         path_valid;
   logic         path_ready;

   modport master (output path, output path_valid, input path_ready);
   modport slave  (input path, input path_valid, output path_ready);
endinterface

// File: rtl/mc_path_gen.sv
// Monte Carlo path source (STEPS-step LFSR walk); first path STEPS+1 cycles after start, then one per STEPS+1.
// Path held and walk frozen while path_ready is low; ANTITHETIC_EN adds a mirrored walker emitted second.
module mc_path_gen #(
   parameter int          W         = 12,
   parameter int          STEPS     = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [W-1:0]      i_s0,
   input  logic signed [7:0] i_mu,
   input  logic [7:0]        i_sigma,
   input  logic [9:0]        i_num_paths,
   output logic              o_busy,
   output logic              o_done,
   mc_path_gen_if.master     o_path_if
);
   localparam int CW = $clog2(STEPS + 1);
   localparam int SW = W + 6;
   localparam logic signed [SW-1:0] C_MAX = {{(SW-W){1'b0}}, {W{1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_WALK, S_EMIT} state_t;

   state_t               r_state;
   logic [15:0]          r_lfsr;
   logic [CW-1:0]        r_step_cnt;
   logic [9:0]           r_path_cnt;
   logic [9:0]           r_num_paths;
   logic [W-1:0]         r_s0;
   logic [W-1:0]         r_s;
   logic [W-1:0]         r_path;
   logic signed [7:0]    r_mu;
   logic [7:0]           r_sigma;
   logic                 r_path_valid;
   logic                 r_busy;
   logic                 r_done;

   logic [15:0]          w_lfsr_nxt;
   logic signed [16:0]   w_prod;
   logic signed [16:0]   w_d;
   logic signed [SW-1:0] w_drift;
   logic signed [SW-1:0] w_dev;
   logic [W-1:0]         w_src_p;
   logic [W-1:0]         w_s_p;
   logic                 w_last;

   function automatic logic [W-1:0] f_sat(input logic signed [SW-1:0] v);
      if (v[SW-1]) return '0;
      if (v > C_MAX) return {W{1'b1}};
      return v[W-1:0];
   endfunction

   assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   assign w_prod     = $signed({9'b0, r_sigma}) * $signed({{9{w_lfsr_nxt[7]}}, w_lfsr_nxt[7:0]});
   assign w_d        = w_prod >>> 6;
   assign w_drift    = {{(SW-8){r_mu[7]}}, r_mu};
   assign w_dev      = {{(SW-17){w_d[16]}}, w_d};
   // The accepting EMIT edge also takes step 1 of the next path, giving STEPS+1 cycles per path.
   assign w_src_p    = (r_state == S_EMIT) ? r_s0 : r_s;
   assign w_s_p      = f_sat($signed({{(SW-W){1'b0}}, w_src_p}) + w_drift + w_dev);
   assign w_last     = ((r_path_cnt + 10'd1) == r_num_paths);

`ifdef ANTITHETIC_EN
   logic [W-1:0] r_sm;
   logic         r_second;
   logic [W-1:0] w_src_m;
   logic [W-1:0] w_s_m;

   assign w_src_m = (r_state == S_EMIT) ? r_s0 : r_sm;
   assign w_s_m   = f_sat($signed({{(SW-W){1'b0}}, w_src_m}) + w_drift - w_dev);
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_lfsr       <= LFSR_SEED;
         r_step_cnt   <= '0;
         r_path_cnt   <= '0;
         r_num_paths  <= '0;
         r_s0         <= '0;
         r_s          <= '0;
         r_path       <= '0;
         r_mu         <= '0;
         r_sigma      <= '0;
         r_path_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
`ifdef ANTITHETIC_EN
         r_sm         <= '0;
         r_second     <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (i_num_paths == 10'd0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_s0        <= i_s0;
                     r_s         <= i_s0;
                     r_mu        <= i_mu;
                     r_sigma     <= i_sigma;
                     r_num_paths <= i_num_paths;
                     r_path_cnt  <= '0;
                     r_step_cnt  <= '0;
                     r_busy      <= 1'b1;
                     r_state     <= S_WALK;
`ifdef ANTITHETIC_EN
                     r_sm        <= i_s0;
`endif
                  end
               end
            end
            S_WALK: begin
               if (r_step_cnt == CW'(STEPS)) begin
                  r_path       <= r_s;
                  r_path_valid <= 1'b1;
                  r_state      <= S_EMIT;
`ifdef ANTITHETIC_EN
                  r_second     <= 1'b0;
`endif
               end else begin
                  r_lfsr     <= w_lfsr_nxt;
                  r_s        <= w_s_p;
                  r_step_cnt <= r_step_cnt + CW'(1);
`ifdef ANTITHETIC_EN
                  r_sm       <= w_s_m;
`endif
               end
            end
            S_EMIT: begin
               if (o_path_if.path_ready) begin
                  r_path_cnt <= r_path_cnt + 10'd1;
`ifdef ANTITHETIC_EN
                  if (!r_second && !w_last) begin
                     r_path   <= r_sm;
                     r_second <= 1'b1;
                  end else
`endif
                  if (w_last) begin
                     r_path_valid <= 1'b0;
                     r_busy       <= 1'b0;
                     r_done       <= 1'b1;
                     r_state      <= S_IDLE;
                  end else begin
                     r_path_valid <= 1'b0;
                     r_lfsr       <= w_lfsr_nxt;
                     r_s          <= w_s_p;
                     r_step_cnt   <= CW'(1);
                     r_state      <= S_WALK;
`ifdef ANTITHETIC_EN
                     r_sm         <= w_s_m;
`endif
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_path_if.path       = r_path;
   assign o_path_if.path_valid = r_path_valid;
   assign o_busy               = r_busy;
   assign o_done               = r_done;
endmodule

// File: tb/tb_mc_path_gen.sv
// Directed bench for mc_path_gen: hand-computed sigma=0 vectors plus a reference random-walk model.
module tb_mc_path_gen;
   localparam int          W     = 12;
   localparam int          STEPS = 16;
   localparam logic [15:0] SEED  = 16'hACE1;
   localparam int          PMAX  = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] s0;
   logic [7:0]   mu;
   logic [7:0]   sigma;
   logic [9:0]   num_paths;
   logic         busy;
   logic         done;
   int           cyc = 0;
   int           n_chk = 0;
   int           n_err = 0;
   logic [15:0]  m_lfsr;

   mc_path_gen_if #(.W(W)) bus ();

   mc_path_gen #(.W(W), .STEPS(STEPS), .LFSR_SEED(SEED)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_s0        (s0),
      .i_mu        (mu),
      .i_sigma     (sigma),
      .i_num_paths (num_paths),
      .o_busy      (busy),
      .o_done      (done),
      .o_path_if   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   function automatic int clamp(input int v);
      return (v < 0) ? 0 : ((v > PMAX) ? PMAX : v);
   endfunction

   // Reference walk: advance, take low byte as signed z, d = floor(sigma*z/64), clamp each step.
   task automatic model_path(input int p_s0, input int p_mu, input int p_sig, output int pp, output int pm);
      logic signed [7:0] z8;
      int d;
      pp = p_s0;
      pm = p_s0;
      for (int k = 0; k < STEPS; k++) begin
         m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
         z8 = m_lfsr[7:0];
         d  = (p_sig * int'(z8)) >>> 6;
         pp = clamp(pp + p_mu + d);
         pm = clamp(pm + p_mu - d);
      end
   endtask

   task automatic apply_start(input int p_s0, input int p_mu, input int p_sig, input int n, output int t0);
      @(negedge clk);
      s0        = p_s0[W-1:0];
      mu        = p_mu[7:0];
      sigma     = p_sig[7:0];
      num_paths = n[9:0];
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      s0        = '0;
      mu        = '0;
      sigma     = '0;
      t0        = cyc;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.path_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // exp_fix >= 0 overrides the model value; lat_step > 0 checks valid arrival cycle.
   task automatic collect(input string tag, input int p_s0, input int p_mu, input int p_sig, input int n,
                          input int t0, input int hold_at, input int exp_fix, input int lat_step);
      int pp;
      int pm;
      int exp_v;
      int first;
      bit ok;
      first = 0;
      for (int i = 0; i < n; i++) begin
`ifdef ANTITHETIC_EN
         if (i % 2 == 0) model_path(p_s0, p_mu, p_sig, pp, pm);
         exp_v = (i % 2 == 0) ? pp : pm;
`else
         model_path(p_s0, p_mu, p_sig, pp, pm);
         exp_v = pp;
`endif
         if (exp_fix >= 0) exp_v = exp_fix;
         wait_valid(4 * STEPS, ok);
         check({tag, "_valid"}, 32'(ok), 32'd1);
         if (!ok) return;
         check({tag, "_path"}, 32'(bus.path), exp_v);
`ifdef ANTITHETIC_EN
         if (i % 2 == 0) first = int'(bus.path);
         else if (exp_fix < 0) check({tag, "_pairsum"}, first + int'(bus.path), 2 * p_s0 + 2 * STEPS * p_mu);
`else
         if (lat_step > 0) check({tag, "_lat"}, cyc - t0, lat_step * (i + 1));
`endif
         if (i == hold_at) begin
            bus.path_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check({tag, "_hold_valid"}, 32'(bus.path_valid), 32'd1);
               check({tag, "_hold_path"}, 32'(bus.path), exp_v);
            end
            bus.path_ready = 1'b1;
         end
         @(posedge clk);
      end
   endtask

   task automatic check_end(input string tag);
      @(negedge clk);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_valid_off"}, 32'(bus.path_valid), 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int  t0;
      bit  seen;
      rst            = 1'b1;
      start          = 1'b0;
      s0             = '0;
      mu             = '0;
      sigma          = '0;
      num_paths      = '0;
      bus.path_ready = 1'b1;
      m_lfsr         = SEED;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_path", 32'(bus.path), 0);
      check("rst_valid", 32'(bus.path_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);

      // Pure drift: 1000 + 16*3
      apply_start(1000, 3, 0, 4, t0);
      check("t1_busy", 32'(busy), 1);
      collect("t1", 1000, 3, 0, 4, t0, -1, 1048, STEPS + 1);
      check_end("t1");

      // Saturation at both rails
      apply_start(4090, 127, 0, 1, t0);
      collect("t2_hi", 4090, 127, 0, 1, t0, -1, PMAX, 0);
      check_end("t2_hi");
      apply_start(5, -128, 0, 1, t0);
      collect("t2_lo", 5, -128, 0, 1, t0, -1, 0, 0);
      check_end("t2_lo");

      // Backpressure on the second path
      apply_start(2048, 0, 64, 3, t0);
      collect("t3", 2048, 0, 64, 3, t0, 1, -1, 0);
      check_end("t3");

      // Zero-path run
      apply_start(100, 5, 0, 0, t0);
      check("t4_done", 32'(done), 1);
      check("t4_busy", 32'(busy), 0);
      seen = 1'b0;
      repeat (STEPS + 4) begin
         @(negedge clk);
         if (bus.path_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
      end
      check("t4_quiet", 32'(seen), 0);

      // Reset mid-run, then rerun from seed
      apply_start(2048, 0, 64, 3, t0);
      collect("t5a", 2048, 0, 64, 1, t0, -1, -1, 0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t5_rst_path", 32'(bus.path), 0);
      check("t5_rst_valid", 32'(bus.path_valid), 0);
      check("t5_rst_busy", 32'(busy), 0);
      check("t5_rst_done", 32'(done), 0);
      rst    = 1'b0;
      m_lfsr = SEED;
      @(negedge clk);
      check("t5_no_done", 32'(done), 0);
      apply_start(2048, 0, 64, 3, t0);
      collect("t5b", 2048, 0, 64, 3, t0, -1, -1, STEPS + 1);
      check_end("t5b");

`ifdef ANTITHETIC_EN
      apply_start(2048, 0, 64, 6, t0);
      collect("t6", 2048, 0, 64, 6, t0, -1, -1, 0);
      check_end("t6");
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
